rr_arb4_sel: RTL and testbench

- Round-robin arbiter for 4 requesters.
- Produces a registered 2-bit winner index `sel` and an `en` qualifier that drive the team's 2-to-4 decoder (`i`/`EN` inputs) directly. The decoder converts them into a one-hot grant.
- Grants are held while the owner keeps requesting, up to a bounded tenure.
- At least one idle cycle separates consecutive grants.

---
 rtl/arb_pkg.sv | 10 +
 rtl/rr_pick4.sv | 22 ++
 rtl/rr_arb4_sel.sv | 66 ++++++
 tb/tb_rr_arb4_sel.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared constants and FSM encoding for the 4-way round-robin arbiter.
package arb_pkg;
  localparam int N_REQ = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;
endpackage

// File: rtl/rr_pick4.sv
// Combinational rotating-priority picker: searches last+1, last+2, last+3, last.
module rr_pick4
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] last,
  output logic [SEL_W-1:0] winner,
  output logic             any
);
  logic [SEL_W-1:0] idx;

  // Walk lowest priority first so the highest-priority hit is the last write.
  always_comb begin
    winner = last;
    idx    = last;
    any    = |req;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = last + SEL_W'(k);
      if (req[idx]) winner = idx;
    end
  end
endmodule

// File: rtl/rr_arb4_sel.sv
// Round-robin arbiter with bounded tenure; drives a 2-to-4 decoder via sel/en.
module rr_arb4_sel
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [SEL_W-1:0] sel,
  output logic             en,
  output logic             expired
);
  arb_state_t       state;
  logic [SEL_W-1:0] last;
  logic [CNT_W-1:0] hold_cnt;
  logic [SEL_W-1:0] winner;
  logic             any;

  rr_pick4 u_pick (
    .req    (req),
    .last   (last),
    .winner (winner),
    .any    (any)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      sel      <= '0;
      en       <= 1'b0;
      expired  <= 1'b0;
      last     <= 2'b11;
      hold_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          expired <= 1'b0;
          if (any) begin
            sel      <= winner;
            last     <= winner;
            en       <= 1'b1;
            hold_cnt <= '0;
            state    <= GRANT;
          end
        end
        GRANT: begin
          // Release is checked first so a drop on the final cycle is not a timeout.
          if (!req[sel]) begin
            en      <= 1'b0;
            expired <= 1'b0;
            state   <= IDLE;
          end else if (hold_cnt == CNT_W'(MAX_HOLD - 1)) begin
            en      <= 1'b0;
            expired <= 1'b1;
            state   <= IDLE;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rr_arb4_sel.sv
// Scoreboard bench for rr_arb4_sel: a cycle model queues expected outputs per edge.
module tb_rr_arb4_sel;
  localparam int MAX_HOLD = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b1111;
  logic [1:0] sel;
  logic       en;
  logic       expired;

  typedef struct {
    logic [1:0] sel;
    logic       en;
    logic       expired;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  // model state
  int   m_busy, m_sel, m_en, m_exp, m_last, m_used;

  rr_arb4_sel #(.MAX_HOLD(MAX_HOLD), .CNT_W(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .sel     (sel),
    .en      (en),
    .expired (expired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_busy = 0; m_sel = 0; m_en = 0; m_exp = 0; m_last = 3; m_used = 0;
  endtask

  // Advance the model by one clock edge with request vector r.
  task automatic model_edge(input logic [3:0] r);
    int idx;
    if (m_busy == 0) begin
      m_exp = 0;
      if (r != 4'b0) begin
        for (int k = 1; k <= 4; k++) begin
          idx = (m_last + k) % 4;
          if (r[idx]) break;
        end
        m_sel = idx; m_last = idx; m_en = 1; m_used = 1; m_busy = 1;
      end
    end else if (!r[m_sel]) begin
      m_en = 0; m_exp = 0; m_busy = 0;
    end else if (m_used == MAX_HOLD) begin
      m_en = 0; m_exp = 1; m_busy = 0;
    end else begin
      m_used++;
    end
  endtask

  // Caller sits just after a rising edge; drive, predict, then compare after the next edge.
  task automatic step(input logic [3:0] r, input string tag);
    exp_t e;
    req = r;
    model_edge(r);
    e.sel = 2'(m_sel); e.en = 1'(m_en); e.expired = 1'(m_exp);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk({tag, "_qempty"}, 0, 1);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_sel"}, int'(sel), int'(e.sel));
      chk({tag, "_en"}, int'(en), int'(e.en));
      chk({tag, "_expired"}, int'(expired), int'(e.expired));
    end
  endtask

  initial begin
    model_reset();
    // reset held with all requests asserted
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("rst_sel", int'(sel), 0);
      chk("rst_en", int'(en), 0);
      chk("rst_expired", int'(expired), 0);
    end
    rst = 1'b0;
    step(4'b1111, "first");
    chk("first_grant_sel", int'(sel), 0);
    chk("first_grant_en", int'(en), 1);
    step(4'b0000, "drain");
    step(4'b0000, "drain");

    // single requester for 3 cycles
    for (int i = 0; i < 3; i++) begin
      step(4'b0100, "single");
      chk("single_sel", int'(sel), 2);
      chk("single_en", int'(en), 1);
    end
    step(4'b0000, "single_drop");
    chk("single_drop_en", int'(en), 0);
    chk("single_drop_exp", int'(expired), 0);

    // saturation: five full tenures with one dead cycle each
    for (int i = 0; i < 5 * (MAX_HOLD + 1); i++) step(4'b1111, "sat");
    chk("sat_last_dead_exp", int'(expired), 1);
    chk("sat_last_sel", int'(sel), 3);

    // wrap-around from 11 to 00 and back to 11
    step(4'b1001, "wrap");
    chk("wrap_first_sel", int'(sel), 0);
    for (int i = 0; i < MAX_HOLD; i++) step(4'b1001, "wrap");
    step(4'b1001, "wrap");
    chk("wrap_second_sel", int'(sel), 3);
    for (int i = 0; i < MAX_HOLD; i++) step(4'b1001, "wrap");

    // async reset in the middle of a grant to 10
    step(4'b0000, "idle");
    step(4'b0000, "idle");
    step(4'b0100, "pre_ar");
    step(4'b0100, "pre_ar");
    chk("pre_ar_sel", int'(sel), 2);
    #2 rst = 1'b1;
    #1;
    chk("ar_en_imm", int'(en), 0);
    chk("ar_sel_imm", int'(sel), 0);
    chk("ar_exp_imm", int'(expired), 0);
    model_reset();
    @(posedge clk);
    #1;
    chk("ar_hold_en", int'(en), 0);
    rst = 1'b0;
    step(4'b0101, "post_ar");
    chk("post_ar_sel", int'(sel), 0);
    step(4'b0000, "idle");
    step(4'b0000, "idle");

    // owner drops on the same edge the tenure would expire
    for (int i = 0; i < MAX_HOLD; i++) step(4'b0010, "simul");
    step(4'b0000, "simul_drop");
    chk("simul_en", int'(en), 0);
    chk("simul_expired", int'(expired), 0);

    // random traffic, sparse and dense
    for (int i = 0; i < 300; i++) begin
      logic [3:0] r;
      r = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) r = 4'b0000;
      step(r, "rand");
    end

    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
